// File: rtl/debug_tx_serializer_if.sv
// rtl/debug_tx_serializer_if.sv - handshake bundle between serializer, debug FSM, database and uart tx
interface debug_tx_serializer_if #(
    parameter int LONGITUD_INSTRUCCION       = 32,
    parameter int OUTPUT_WORD_LENGTH         = 8,
    parameter int CANT_BITS_CONTROL_DATABASE = 3
);
    logic                                  i_start;
    logic                                  i_tx_done;
    logic [LONGITUD_INSTRUCCION-1:0]       i_dato_database;
    logic [CANT_BITS_CONTROL_DATABASE-1:0] o_control_database;
    logic                                  o_tx_start;
    logic [OUTPUT_WORD_LENGTH-1:0]         o_data_tx;
    logic                                  o_busy;
    logic                                  o_done;
    logic                                  o_error;

    modport master (
        input  i_start, i_tx_done, i_dato_database,
        output o_control_database, o_tx_start, o_data_tx, o_busy, o_done, o_error
    );

    modport slave (
        output i_start, i_tx_done, i_dato_database,
        input  o_control_database, o_tx_start, o_data_tx, o_busy, o_done, o_error
    );
endinterface

// File: rtl/debug_tx_serializer.sv
// rtl/debug_tx_serializer.sv - walks database entries and feeds their bytes MSB first to the uart tx
module debug_tx_serializer #(
    parameter int LONGITUD_INSTRUCCION       = 32,
    parameter int OUTPUT_WORD_LENGTH         = 8,
    parameter int CANT_BITS_CONTROL_DATABASE = 3,
    parameter int CANT_DATOS                 = 5,
    parameter int TIMEOUT_CICLOS             = 100000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    debug_tx_serializer_if.master bus
);
    localparam int NB  = LONGITUD_INSTRUCCION / OUTPUT_WORD_LENGTH;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CBW = CANT_BITS_CONTROL_DATABASE;
    localparam int TW  = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEL0,
        SEL1,
        SEND,
        WAIT,
        FIN,
        ABORT
    } state_t;

    state_t                          state;
    logic [LONGITUD_INSTRUCCION-1:0] shift;
    logic [BCW-1:0]                  byte_cnt;
    logic [CBW-1:0]                  idx;
    logic [TW-1:0]                   tmo;
    logic                            tx_done_q;
    logic                            done_edge;

    // Only a fresh rising edge counts, so a level left high by the tx is never mistaken for a completion.
    assign done_edge = bus.i_tx_done & ~tx_done_q;

    // Transfer sequencer: select entry, capture word, send bytes, track timeout; all outputs registered.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state                  <= IDLE;
            shift                  <= '0;
            byte_cnt               <= '0;
            idx                    <= '0;
            tmo                    <= '0;
            tx_done_q              <= 1'b0;
            bus.o_control_database <= '0;
            bus.o_tx_start         <= 1'b0;
            bus.o_data_tx          <= '0;
            bus.o_busy             <= 1'b0;
            bus.o_done             <= 1'b0;
            bus.o_error            <= 1'b0;
        end else begin
            tx_done_q      <= bus.i_tx_done;
            bus.o_tx_start <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        idx                    <= '0;
                        bus.o_control_database <= CBW'(1);
                        bus.o_busy             <= 1'b1;
                        state                  <= SEL0;
                    end
                end
                SEL0: begin
                    // Database output is registered; give it a cycle to follow the new select.
                    state <= SEL1;
                end
                SEL1: begin
                    shift    <= bus.i_dato_database;
                    byte_cnt <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    bus.o_tx_start <= 1'b1;
                    bus.o_data_tx  <= shift[LONGITUD_INSTRUCCION-1 -: OUTPUT_WORD_LENGTH];
                    tmo            <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (done_edge) begin
                        if (byte_cnt < BCW'(NB - 1)) begin
                            shift    <= shift << OUTPUT_WORD_LENGTH;
                            byte_cnt <= byte_cnt + BCW'(1);
                            state    <= SEND;
                        end else if (idx < CBW'(CANT_DATOS - 1)) begin
                            idx                    <= idx + CBW'(1);
                            bus.o_control_database <= idx + CBW'(2);
                            state                  <= SEL0;
                        end else begin
                            bus.o_done <= 1'b1;
                            state      <= FIN;
                        end
                    end else if (tmo == TW'(TIMEOUT_CICLOS - 1)) begin
                        bus.o_error <= 1'b1;
                        state       <= ABORT;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                FIN, ABORT: begin
                    bus.o_control_database <= '0;
                    bus.o_busy             <= 1'b0;
                    state                  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_tx_serializer.sv
// tb/tb_debug_tx_serializer.sv - self-checking bench for debug_tx_serializer
module tb_debug_tx_serializer;
    localparam int L      = 32;
    localparam int O      = 8;
    localparam int CB     = 3;
    localparam int CD     = 2;
    localparam int T      = 50;
    localparam int NB     = L / O;
    localparam int NBYTES = NB * CD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_tx_serializer_if #(
        .LONGITUD_INSTRUCCION(L),
        .OUTPUT_WORD_LENGTH(O),
        .CANT_BITS_CONTROL_DATABASE(CB)
    ) bus ();

    debug_tx_serializer #(
        .LONGITUD_INSTRUCCION(L),
        .OUTPUT_WORD_LENGTH(O),
        .CANT_BITS_CONTROL_DATABASE(CB),
        .CANT_DATOS(CD),
        .TIMEOUT_CICLOS(T)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    logic [L-1:0] entries [CD];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // registered database: word follows the select one clock later
    always @(posedge clk) begin
        if (int'(bus.o_control_database) >= 1 && int'(bus.o_control_database) <= CD)
            bus.i_dato_database <= entries[int'(bus.o_control_database) - 1];
        else
            bus.i_dato_database <= '0;
    end

    // inputs as the DUT saw them at each rising edge
    logic s_start, s_done, s_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_start <= 1'b0;
            s_done  <= 1'b0;
            s_prev  <= 1'b0;
        end else begin
            s_prev  <= s_done;
            s_done  <= bus.i_tx_done;
            s_start <= bus.i_start;
        end
    end

    // tx model: 0 pulse 20 cycles after start, 1 level high dropping after start, 2 never done, 3 as 0 plus a stray pulse
    int mode = 0;
    int stray_cyc = -1;
    int cd = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cd = 0;
            #1 bus.i_tx_done = 1'b0;
        end else begin
            if (bus.o_tx_start) cd = 20;
            else if (cd > 0) cd--;
            #1;
            case (mode)
                1:       bus.i_tx_done = (cd <= 1);
                2:       bus.i_tx_done = 1'b0;
                default: bus.i_tx_done = (cd == 1) || (cyc == stray_cyc);
            endcase
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [O-1:0] byte_of(input int k);
        logic [L-1:0] w;
        w = entries[k / NB];
        return w[(NB - 1 - k % NB) * O +: O];
    endfunction

    // behavioural model: event times derived from handshake rules
    bit            m_active = 0, m_wait = 0;
    int            k = 0, t_last = -1, next_tx = -1, done_c = -1, err_c = -1, end_c = -1;
    logic [CB-1:0] m_ctrl = '0;
    logic          m_busy = 1'b0;
    logic [O-1:0]  m_data = '0;

    // recorder
    logic [O-1:0]  got_bytes [$];
    int            tx_cycles [$];
    logic [CB-1:0] ctrl_log  [$];
    logic [CB-1:0] last_ctrl = '0;
    logic          last_busy = 1'b0;
    int n_tx = 0, n_done = 0, n_err = 0, done_at = -1, err_at = -1, busy_fall = -1;

    task automatic step();
        int n;
        @(negedge clk);
        n = cyc;
        if (!rst_n) begin
            m_active = 0; m_wait = 0; m_ctrl = '0; m_busy = 1'b0; m_data = '0;
            t_last = -1; next_tx = -1; done_c = -1; err_c = -1; end_c = -1;
        end else begin
            if (!m_active && s_start) begin
                m_active = 1; m_ctrl = CB'(1); m_busy = 1'b1; k = 0; next_tx = n + 3;
            end else if (m_wait && s_done && !s_prev) begin
                m_wait = 0;
                if (k == NBYTES - 1) begin
                    done_c = n; end_c = n + 1;
                end else if ((k + 1) % NB == 0) begin
                    m_ctrl = CB'((k + 1) / NB + 1); next_tx = n + 3;
                end else begin
                    next_tx = n + 1;
                end
                k++;
            end else if (m_wait && n == t_last + T) begin
                m_wait = 0; err_c = n; end_c = n + 1;
            end
            if (n == next_tx) begin
                m_wait = 1; t_last = n; m_data = byte_of(k);
            end
            if (n == end_c) begin
                m_active = 0; m_ctrl = '0; m_busy = 1'b0;
            end
        end
        chk("tx_start", 32'(bus.o_tx_start), 32'(n == t_last));
        chk("data_tx", 32'(bus.o_data_tx), 32'(m_data));
        chk("done", 32'(bus.o_done), 32'(n == done_c));
        chk("error", 32'(bus.o_error), 32'(n == err_c));
        chk("control", 32'(bus.o_control_database), 32'(m_ctrl));
        chk("busy", 32'(bus.o_busy), 32'(m_busy));
        if (bus.o_tx_start) begin got_bytes.push_back(bus.o_data_tx); tx_cycles.push_back(n); n_tx++; end
        if (bus.o_done) begin n_done++; done_at = n; end
        if (bus.o_error) begin n_err++; err_at = n; end
        if (bus.o_control_database !== last_ctrl) ctrl_log.push_back(bus.o_control_database);
        last_ctrl = bus.o_control_database;
        if (last_busy && !bus.o_busy) busy_fall = n;
        last_busy = bus.o_busy;
    endtask

    task automatic pulse_start(output int c);
        step();
        c = cyc;
        #1 bus.i_start = 1'b1;
        step();
        #1 bus.i_start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int d0, input int e0);
        int g = 0;
        while (n_done == d0 && n_err == e0 && g < 1500) begin step(); g++; end
        chk({nm, "_finished"}, 32'(g < 1500), 32'd1);
        repeat (3) step();
    endtask

    logic [O-1:0] exp_seq [NBYTES];
    int c, b0, t0, d0, e0, c0, g;

    task automatic check_seq(input string nm, input int base);
        for (int i = 0; i < NBYTES; i++)
            chk(nm, 32'((base + i < got_bytes.size()) ? got_bytes[base + i] : 8'hxx), 32'(exp_seq[i]));
    endtask

    initial begin
        entries[0] = 32'h12345678;
        entries[1] = 32'hCAFEBABE;
        exp_seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        bus.i_start = 1'b0;
        repeat (3) step();
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        chk("reset_ctrl", 32'(bus.o_control_database), 32'd0);
        chk("reset_data", 32'(bus.o_data_tx), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // basic transfer, tx pulses done 20 cycles after each start
        mode = 0;
        b0 = got_bytes.size(); t0 = n_tx; d0 = n_done; e0 = n_err; c0 = ctrl_log.size();
        pulse_start(c);
        wait_end("t1", d0, e0);
        check_seq("t1_byte", b0);
        chk("t1_tx_count", 32'(n_tx - t0), 32'd8);
        chk("t1_done_count", 32'(n_done - d0), 32'd1);
        chk("t1_latency", 32'(tx_cycles[b0] - c), 32'd4);
        chk("t1_next_byte_gap", 32'(tx_cycles[b0 + 1] - tx_cycles[b0]), 32'd21);
        chk("t1_next_entry_gap", 32'(tx_cycles[b0 + 4] - tx_cycles[b0 + 3]), 32'd23);
        chk("t1_ctrl_changes", 32'(ctrl_log.size() - c0), 32'd3);
        chk("t1_ctrl_a", 32'(ctrl_log[c0]), 32'd1);
        chk("t1_ctrl_b", 32'(ctrl_log[c0 + 1]), 32'd2);
        chk("t1_ctrl_c", 32'(ctrl_log[c0 + 2]), 32'd0);
        chk("t1_busy_fall", 32'(busy_fall - done_at), 32'd1);

        // tx_done held high before start, dropping after each start
        mode = 1;
        repeat (5) step();
        b0 = got_bytes.size(); t0 = n_tx; d0 = n_done; e0 = n_err;
        pulse_start(c);
        wait_end("t2", d0, e0);
        check_seq("t2_byte", b0);
        chk("t2_tx_count", 32'(n_tx - t0), 32'd8);
        chk("t2_done_count", 32'(n_done - d0), 32'd1);

        // tx never completes: timeout abort, then restart from entry 0
        mode = 2;
        repeat (5) step();
        b0 = got_bytes.size(); t0 = n_tx; d0 = n_done; e0 = n_err;
        pulse_start(c);
        wait_end("t3", d0, e0);
        chk("t3_tx_count", 32'(n_tx - t0), 32'd1);
        chk("t3_byte", 32'(got_bytes[b0]), 32'h12);
        chk("t3_err_count", 32'(n_err - e0), 32'd1);
        chk("t3_no_done", 32'(n_done - d0), 32'd0);
        chk("t3_err_delay", 32'(err_at - tx_cycles[b0]), 32'd50);
        chk("t3_ctrl_idle", 32'(bus.o_control_database), 32'd0);
        mode = 0;
        b0 = got_bytes.size(); d0 = n_done; e0 = n_err;
        pulse_start(c);
        wait_end("t3r", d0, e0);
        check_seq("t3r_byte", b0);
        chk("t3r_done_count", 32'(n_done - d0), 32'd1);

        // repeated start requests while busy
        b0 = got_bytes.size(); t0 = n_tx; d0 = n_done; e0 = n_err;
        pulse_start(c);
        g = 0;
        while (!bus.o_done && bus.o_busy && g < 1500) begin
            step();
            g++;
            if (g % 5 == 0) begin
                #1 bus.i_start = 1'b1;
                step();
                #1 bus.i_start = 1'b0;
            end
        end
        wait_end("t4", d0, e0);
        check_seq("t4_byte", b0);
        chk("t4_tx_count", 32'(n_tx - t0), 32'd8);
        chk("t4_done_count", 32'(n_done - d0), 32'd1);

        // reset during the third byte's wait
        t0 = n_tx; d0 = n_done; e0 = n_err;
        pulse_start(c);
        g = 0;
        while (n_tx - t0 < 3 && g < 500) begin step(); g++; end
        chk("t5_reached_byte3", 32'(n_tx - t0), 32'd3);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("t5_rst_ctrl", 32'(bus.o_control_database), 32'd0);
        chk("t5_rst_data", 32'(bus.o_data_tx), 32'd0);
        chk("t5_rst_start", 32'(bus.o_tx_start), 32'd0);
        repeat (2) step();
        #1 rst_n = 1'b1;
        repeat (30) step();
        chk("t5_stays_idle", 32'(bus.o_busy), 32'd0);
        chk("t5_no_more_tx", 32'(n_tx - t0), 32'd3);
        chk("t5_no_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);

        // stray done pulse coincident with the first SEND
        mode = 3;
        b0 = got_bytes.size(); t0 = n_tx; d0 = n_done; e0 = n_err;
        pulse_start(c);
        stray_cyc = c + 3;
        wait_end("t6", d0, e0);
        stray_cyc = -1;
        check_seq("t6_byte", b0);
        chk("t6_tx_count", 32'(n_tx - t0), 32'd8);
        chk("t6_second_gap", 32'(tx_cycles[b0 + 1] - tx_cycles[b0]), 32'd21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
